// File: rtl/prog_clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clk_div_pkg;

  // Smallest divisor that still yields one low and one high cycle per period.
  localparam int unsigned MIN_DIV   = 2;
  // Widest divisor the clamp helper handles.
  localparam int unsigned MAX_WIDTH = 32;

  // Raise divisors below MIN_DIV to MIN_DIV; larger values pass unchanged.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    logic [31:0] r;
    if (v < 32'(MIN_DIV)) begin
      r = 32'(MIN_DIV);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Divisor write port: strobe, channel select, value and per-channel pending flags.
interface prog_clk_div_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 27
) ();
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                div_load;
  logic [CH_W-1:0]     div_ch;
  logic [WIDTH-1:0]    div_val;
  logic [CHANNELS-1:0] div_pend;

  modport master (output div_load, output div_ch, output div_val, input  div_pend);
  modport slave  (input  div_load, input  div_ch, input  div_val, output div_pend);
endinterface

// File: rtl/prog_clk_div_chan.sv
// One divider channel: period counter, active and pending divisor, registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 27,
  parameter int DEFAULT_DIV = 10000
) (
  input  logic             inclk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_val,
  output logic             o_pend,
  output logic             o_outclk,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_pend_div;
  logic             r_pend;
  logic             r_outclk;
  logic             r_tick;

  logic             w_wrap;
  logic             w_bound;
  logic [WIDTH-1:0] w_cnt_n;
  logic [WIDTH-1:0] w_low;

  // Next count and low-phase length; a disabled channel is always at a boundary.
  always_comb begin
    w_wrap  = (r_cnt == (r_div - WIDTH'(1)));
    w_bound = !i_en || w_wrap;
    w_low   = r_div - (r_div >> 1);
    if (w_wrap) begin
      w_cnt_n = '0;
    end else begin
      w_cnt_n = r_cnt + WIDTH'(1);
    end
  end

  // Counter, outputs and divisor hand-over; a write on a boundary skips the pending slot.
  always_ff @(posedge inclk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_div      <= WIDTH'(DEFAULT_DIV);
      r_pend_div <= WIDTH'(DEFAULT_DIV);
      r_pend     <= 1'b0;
      r_outclk   <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      if (i_en) begin
        r_cnt    <= w_cnt_n;
        r_outclk <= (w_cnt_n >= w_low);
        r_tick   <= (w_cnt_n == w_low);
      end else begin
        r_cnt    <= '0;
        r_outclk <= 1'b0;
        r_tick   <= 1'b0;
      end

      if (w_bound) begin
        if (i_load) begin
          r_div <= i_val;
        end else if (r_pend) begin
          r_div <= r_pend_div;
        end else begin
          r_div <= r_div;
        end
        r_pend <= 1'b0;
      end else if (i_load) begin
        r_pend_div <= i_val;
        r_pend     <= 1'b1;
      end else begin
        r_pend <= r_pend;
      end
    end
  end

  assign o_pend   = r_pend;
  assign o_outclk = r_outclk;
  assign o_tick   = r_tick;

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider: write-port decode plus CHANNELS divider channels.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 27,
  parameter int DEFAULT_DIV = 10000
) (
  input  logic                inclk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  prog_clk_div_if.slave       wr_if,
  output logic [CHANNELS-1:0] outclk,
  output logic [CHANNELS-1:0] tick
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("prog_clk_div: CHANNELS must be 1..16");
  end
  if (WIDTH < 2 || WIDTH > int'(MAX_WIDTH)) begin : g_bad_width
    $error("prog_clk_div: WIDTH out of range");
  end
  if (DEFAULT_DIV < 2 || 64'(DEFAULT_DIV) >= (64'd1 << WIDTH)) begin : g_bad_default
    $error("prog_clk_div: DEFAULT_DIV must be >= 2 and < 2**WIDTH");
  end

  logic [CHANNELS-1:0] w_load;
  logic [CHANNELS-1:0] w_pend;
  logic [WIDTH-1:0]    w_val;
  logic                w_in_range;

  // Clamp the written value and turn the channel select into a one-hot load strobe.
  always_comb begin
    w_in_range = (32'(wr_if.div_ch) < 32'(CHANNELS));
    w_val      = WIDTH'(clamp_div(32'(wr_if.div_val)));
    w_load     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_load[i] = wr_if.div_load && w_in_range && (32'(wr_if.div_ch) == 32'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .inclk    (inclk),
      .rst      (rst),
      .i_en     (en[g]),
      .i_load   (w_load[g]),
      .i_val    (w_val),
      .o_pend   (w_pend[g]),
      .o_outclk (outclk[g]),
      .o_tick   (tick[g])
    );
  end

  assign wr_if.div_pend = w_pend;

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: vector table, directed corner sequences, random run vs model.
module tb_prog_clk_div;
  localparam int CH = 3;
  localparam int W  = 8;
  localparam int DD = 4;

  logic          inclk;
  logic          rst;
  logic [CH-1:0] en;
  logic [CH-1:0] outclk;
  logic [CH-1:0] tick;

  prog_clk_div_if #(.CHANNELS(CH), .WIDTH(W)) wr_if ();

  prog_clk_div #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DD)) dut (
    .inclk  (inclk),
    .rst    (rst),
    .en     (en),
    .wr_if  (wr_if),
    .outclk (outclk),
    .tick   (tick)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the current period plus divisor bookkeeping.
  int          m_age [CH];
  int          m_d   [CH];
  int          m_p   [CH];
  bit          m_pend[CH];
  logic [CH-1:0] m_out;
  logic [CH-1:0] m_tick;

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int  v;
    int  lo;
    bit  ld;
    bit  at;
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_age[c] = 0; m_d[c] = DD; m_p[c] = DD; m_pend[c] = 1'b0;
      end
      m_out  = '0;
      m_tick = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        v  = int'(wr_if.div_val);
        if (v < 2) v = 2;
        ld = wr_if.div_load && (int'(wr_if.div_ch) == c);
        at = !en[c] || (m_age[c] == m_d[c] - 1);
        if (en[c]) begin
          m_age[c]  = (m_age[c] + 1) % m_d[c];
          lo        = m_d[c] - m_d[c] / 2;
          m_out[c]  = (m_age[c] >= lo);
          m_tick[c] = (m_age[c] == lo);
        end else begin
          m_age[c]  = 0;
          m_out[c]  = 1'b0;
          m_tick[c] = 1'b0;
        end
        if (at) begin
          if (ld) m_d[c] = v;
          else if (m_pend[c]) m_d[c] = m_p[c];
          m_pend[c] = 1'b0;
        end else if (ld) begin
          m_p[c]    = v;
          m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    logic [CH-1:0] pv;
    @(posedge inclk);
    model_update();
    @(negedge inclk);
    for (int c = 0; c < CH; c++) pv[c] = m_pend[c];
    check("model_outclk", outclk, m_out);
    check("model_tick", tick, m_tick);
    check("model_pend", wr_if.div_pend, pv);
  endtask

  task automatic idle();
    wr_if.div_load = 1'b0;
    step();
  endtask

  task automatic load(input int ch, input int val);
    wr_if.div_load = 1'b1;
    wr_if.div_ch   = 2'(ch);
    wr_if.div_val  = W'(val);
    step();
    wr_if.div_load = 1'b0;
  endtask

  // Steps until tick[c] is seen; n is the number of edges taken (bound+1 if never seen).
  task automatic count_to_tick(input int c, input int bound, output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (!tick[c] && n <= bound);
  endtask

  typedef struct {
    logic          rst;
    logic [CH-1:0] en;
    logic          load;
    logic [1:0]    ch;
    logic [W-1:0]  val;
    logic [CH-1:0] out;
    logic [CH-1:0] tck;
    logic [CH-1:0] pend;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;
    logic [4:0]    seq;
    logic [CH-1:0] prev;

    tbl[0]  = '{1'b1, 3'b000, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[1]  = '{1'b0, 3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[2]  = '{1'b0, 3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000};
    tbl[3]  = '{1'b0, 3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 3'b000};
    tbl[4]  = '{1'b0, 3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[5]  = '{1'b0, 3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[6]  = '{1'b0, 3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b111, 3'b000};
    tbl[7]  = '{1'b0, 3'b111, 1'b0, 2'd0, 8'd0, 3'b111, 3'b000, 3'b000};
    tbl[8]  = '{1'b0, 3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000};
    tbl[9]  = '{1'b0, 3'b111, 1'b1, 2'd3, 8'd5, 3'b000, 3'b000, 3'b000};
    tbl[10] = '{1'b0, 3'b111, 1'b1, 2'd0, 8'd1, 3'b111, 3'b111, 3'b001};

    for (int c = 0; c < CH; c++) begin
      m_age[c] = 0; m_d[c] = DD; m_p[c] = DD; m_pend[c] = 1'b0;
    end
    m_out = '0; m_tick = '0;
    rst = 1'b1; en = '0;
    wr_if.div_load = 1'b0; wr_if.div_ch = '0; wr_if.div_val = '0;

    // Reset, default divide-by-4 waveform, out-of-range write, clamped write.
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; en = tbl[i].en;
      wr_if.div_load = tbl[i].load; wr_if.div_ch = tbl[i].ch; wr_if.div_val = tbl[i].val;
      step();
      check($sformatf("vec%0d_outclk", i), outclk, tbl[i].out);
      check($sformatf("vec%0d_tick", i), tick, tbl[i].tck);
      check($sformatf("vec%0d_pend", i), wr_if.div_pend, tbl[i].pend);
    end
    wr_if.div_load = 1'b0;

    // ch1 <- 5 mid-period: pending until boundary, then low 3 / high 2.
    load(1, 5);
    check_int("ch1_pend_set", int'(wr_if.div_pend[1]), 1);
    n = 0;
    while (wr_if.div_pend[1] && n < 12) begin idle(); n++; end
    check_int("ch1_pend_clear", int'(wr_if.div_pend[1]), 0);
    seq = {4'b0000, outclk[1]};
    for (int k = 0; k < 4; k++) begin idle(); seq = {seq[3:0], outclk[1]}; end
    check_int("ch1_div5_shape", int'(seq), 5'b00011);

    // ch2 <- 0 (clamped to 2); ch0 already holds clamped 2: both toggle every cycle.
    load(2, 0);
    for (int k = 0; k < 6; k++) idle();
    for (int k = 0; k < 4; k++) begin
      prev = outclk;
      idle();
      check("clamp_toggle", outclk & 3'b101, ~prev & 3'b101);
      check("clamp_tick", tick & 3'b101, outclk & 3'b101);
    end

    // Two writes 7 then 9 within one period: only 9 takes effect.
    count_to_tick(1, 20, n);
    idle(); idle();
    load(1, 7);
    load(1, 9);
    check_int("ch1_pend_two", int'(wr_if.div_pend[1]), 1);
    n = 0;
    while (wr_if.div_pend[1] && n < 12) begin idle(); n++; end
    count_to_tick(1, 20, n);
    check_int("ch1_div9_first_tick", n, 5);
    count_to_tick(1, 20, n);
    check_int("ch1_div9_period", n, 9);

    // Write on the boundary cycle applies at once, pending stays clear.
    idle(); idle(); idle();
    load(1, 6);
    check_int("ch1_boundary_pend", int'(wr_if.div_pend[1]), 0);
    count_to_tick(1, 20, n);
    check_int("ch1_div6_first_tick", n, 3);
    count_to_tick(1, 20, n);
    check_int("ch1_div6_period", n, 6);

    // Drop en mid-high with a pending write; re-enable rises after L=2 edges.
    load(1, 4);
    check_int("ch1_high_before_drop", int'(outclk[1]), 1);
    en = 3'b101;
    idle();
    check_int("ch1_drop_out", int'(outclk[1]), 0);
    check_int("ch1_drop_pend", int'(wr_if.div_pend[1]), 0);
    idle();
    en = 3'b111;
    count_to_tick(1, 20, n);
    check_int("ch1_reenable_rise", n, 2);

    // Reset beats a same-cycle write.
    rst = 1'b1;
    load(0, 9);
    check("rst_outclk", outclk, 3'b000);
    check("rst_tick", tick, 3'b000);
    check("rst_pend", wr_if.div_pend, 3'b000);
    rst = 1'b0;
    count_to_tick(0, 20, n);
    check_int("rst_default_first_tick", n, 2);
    count_to_tick(0, 20, n);
    check_int("rst_default_period", n, DD);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < CH; c++) en[c] = ($urandom_range(0, 7) != 0);
      wr_if.div_load = ($urandom_range(0, 3) == 0);
      wr_if.div_ch   = 2'($urandom_range(0, 3));
      wr_if.div_val  = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 12));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
# prog_clk_div

Multi-channel programmable clock divider generating CHANNELS independent divided clock-enables and square-wave outputs from a single input clock. Each channel has a run-time divisor, loaded through a shared write port and applied glitch-free at that channel's next period boundary. It feeds the modulator and sample-rate timing paths that previously used fixed, elaboration-time dividers. Adds synchronous reset, per-channel enable, odd-divisor support and a single-cycle tick per period.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 27, divisor and counter width in bits
- DEFAULT_DIV, 10000, divisor loaded into every channel at reset; elaboration error if < 2 or ≥ 2^WIDTH
- inclk  input  1  sole clock; all logic on posedge
- rst  input  1  synchronous, active-high reset
- en  input  CHANNELS  per-channel run enable
- div_load  input  1  write strobe, one cycle per write
- div_ch  input  max(1,$clog2(CHANNELS))  target channel of write
- div_val  input  WIDTH  new divisor
- div_pend  output  CHANNELS  channel has an unapplied divisor
- outclk  output  CHANNELS  divided square wave, registered
- tick  output  CHANNELS  one-cycle pulse, high in the cycle outclk first goes high each period

## Operation
- Per channel state: cnt (WIDTH), active divisor D, pending divisor P, pend flag.
- Reset: cnt=0, D=DEFAULT_DIV, pend=0, outclk=0, tick=0, div_pend=0. Reset overrides all other inputs, including a same-cycle div_load.
- Phases: L = D − (D>>1) low cycles, H = D>>1 high cycles; odd D gives the extra cycle to the low phase.
- Each edge with en=1: cnt_n = (cnt==D−1) ? 0 : cnt+1; cnt<=cnt_n; outclk<=(cnt_n ≥ L); tick<=(cnt_n == L).
- Boundary = edge where cnt==D−1 and en=1. If pend set: D<=P, pend<=0; cnt<=0 and the low phase of the new period uses the new D.
- en=0: next edge cnt<=0, outclk<=0, tick<=0; if pend set, D<=P and pend<=0 on that edge. Re-enable restarts from cnt=0 (low phase).
- Write: when div_load=1, the value is clamped: div_val<2 becomes 2. If div_ch<CHANNELS: P<=clamped, pend<=1. If div_ch≥CHANNELS: write ignored, no state change.
- Write to a channel already pending: P overwritten, only the last value is applied.
- Write in the same cycle as that channel's boundary: the new value bypasses P and becomes D at that boundary; pend stays 0.
- Counter wrap never exceeds D−1; arithmetic unsigned, no overflow possible since D ≤ 2^WIDTH−1.

## Timing
- outclk and tick are registered, with no combinational path from inputs.
- First rising outclk occurs L edges after rst release with en held 1. Period is exactly D inclk cycles; duty is H/D.
- div_pend rises on the edge after div_load and falls on the applying boundary edge.
- Divisor change latency: at most the remainder of the current period + 1 cycle; never a truncated or runt pulse.
- D=2: outclk toggles every cycle and tick is high every other cycle.

## Structure
- Package clk_div_pkg contains MIN_DIV=2 and a clamp function for the divisor.
- Sub-module clk_div_chan holds one channel (cnt, D, P, pend, outputs) and is generated CHANNELS times. The top level decodes div_ch into a one-hot load vector per channel.

## Test plan
- DEFAULT_DIV=4, en=1 after reset: outclk shows 0,0,1,1 repeating; tick high on edges 2, 6, 10; div_pend=0.
- Load ch1 div_val=5 mid-period: div_pend[1]=1 until the boundary. The next period is low 3 / high 2. Other channels are unaffected.
- div_val=0 and div_val=1 are each clamped to 2 (toggle every cycle). A write with div_ch=CHANNELS is ignored.
- Two writes (7 then 9) before the boundary: only 9 is applied. A write landing on the boundary cycle applies immediately, with div_pend staying 0.
- en dropped mid-high: outclk=0 on the next edge, and the pending value is applied. Re-enable gives the first rise after L edges.
- rst asserted mid-period with div_load=1: all outputs 0, D=DEFAULT_DIV, pend=0 on the next edge.
